// File: rtl/gold_catch_pkg.sv
// Shared types and helpers for the gold-catch arbiter: hook FSM states,
// default sizing constants and a lowest-set-bit finder.
package gold_catch_pkg;

    localparam int unsigned DefNItems        = 8;
    localparam int unsigned DefValW          = 8;
    localparam int unsigned DefTimeoutCycles = 50000000;

    // lowest_set works on a fixed-width mask; N_ITEMS must not exceed MaxItems.
    localparam int unsigned MaxItems = 64;
    localparam int unsigned IdxW     = 6;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        PULL,
        CREDIT,
        BLAST
    } hook_state_t;

    typedef enum logic {
        PrioLeft,
        PrioRight
    } prio_t;

    typedef struct packed {
        logic            valid;
        logic [IdxW-1:0] idx;
    } lowest_t;

    function automatic lowest_t lowest_set(input logic [MaxItems-1:0] mask);
        lowest_t res;
        res.valid = 1'b0;
        res.idx   = '0;
        for (int i = MaxItems - 1; i >= 0; i--) begin
            if (mask[i]) begin
                res.valid = 1'b1;
                res.idx   = i[IdxW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hook_claim_fsm.sv
// Per-hook claim FSM: IDLE -> GRANT -> PULL -> CREDIT/BLAST -> IDLE.
// Pull timeout counter exists only when CATCH_TIMEOUT_EN is defined.
module hook_claim_fsm
    import gold_catch_pkg::*;
#(
    parameter int unsigned N_ITEMS        = DefNItems,
    parameter int unsigned VAL_W          = DefValW,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                     Clk,
    input  logic                     clear,
    input  logic [N_ITEMS-1:0]       award_mask,
    input  logic [N_ITEMS*VAL_W-1:0] item_value,
    input  logic                     hook_home,
    input  logic                     is_explode,
    output logic                     idle,
    output logic                     busy,
    output logic [N_ITEMS-1:0]       grant,
    output logic [N_ITEMS-1:0]       release_mask,
    output logic                     score_pulse,
    output logic [VAL_W-1:0]         score_add,
    output logic                     timeout
);

    hook_state_t        state_q;
    logic [N_ITEMS-1:0] grant_q;
    logic               score_pulse_q;
    logic [VAL_W-1:0]   score_add_q;
    logic               timeout_q;
    logic [VAL_W-1:0]   value_sel;

    always_comb begin
        value_sel = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (grant_q[i]) value_sel = value_sel | item_value[i*VAL_W +: VAL_W];
        end
    end

`ifdef CATCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CntW-1:0] cnt_q;
    logic            at_limit;

    assign at_limit     = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    // Home and explode take precedence over an expiring counter.
    assign release_mask = (state_q == PULL && !is_explode && !hook_home && at_limit) ?
                          grant_q : '0;
`else
    assign release_mask = '0;
`endif

    always_ff @(posedge Clk) begin
        if (clear) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            score_pulse_q <= 1'b0;
            score_add_q   <= '0;
            timeout_q     <= 1'b0;
`ifdef CATCH_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            score_pulse_q <= 1'b0;
            score_add_q   <= '0;
            timeout_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (|award_mask) begin
                        state_q <= GRANT;
                        grant_q <= award_mask;
                    end
                end
                GRANT: begin
                    state_q <= PULL;
`ifdef CATCH_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                PULL: begin
                    if (is_explode) begin
                        state_q <= BLAST;
                    end else if (hook_home) begin
                        state_q       <= CREDIT;
                        score_pulse_q <= 1'b1;
                        score_add_q   <= value_sel;
`ifdef CATCH_TIMEOUT_EN
                    end else if (at_limit) begin
                        state_q   <= IDLE;
                        grant_q   <= '0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                CREDIT, BLAST: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign idle        = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign grant       = grant_q;
    assign score_pulse = score_pulse_q;
    assign score_add   = score_add_q;
    assign timeout     = timeout_q;

endmodule

// File: rtl/gold_catch_arbiter.sv
// Two-hook item arbiter: owns the taken mask and the contention priority bit.
// Optional feature: CATCH_TIMEOUT_EN enables the per-hook pull abort timer.
module gold_catch_arbiter
    import gold_catch_pkg::*;
#(
    parameter int unsigned N_ITEMS        = DefNItems,
    parameter int unsigned VAL_W          = DefValW,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                     Clk,
    input  logic                     reset_n,
    input  logic                     is_new_game_start,
    input  logic [N_ITEMS-1:0]       hitl,
    input  logic [N_ITEMS-1:0]       hitr,
    input  logic [N_ITEMS*VAL_W-1:0] item_value,
    input  logic                     hook_homel,
    input  logic                     hook_homer,
    input  logic                     is_explodel,
    input  logic                     is_exploder,
    output logic [N_ITEMS-1:0]       grantl,
    output logic [N_ITEMS-1:0]       grantr,
    output logic [N_ITEMS-1:0]       taken,
    output logic                     busyl,
    output logic                     busyr,
    output logic                     score_pulsel,
    output logic                     score_pulser,
    output logic [VAL_W-1:0]         score_addl,
    output logic [VAL_W-1:0]         score_addr,
    output logic                     timeoutl,
    output logic                     timeoutr
);

    logic               clear;
    logic [N_ITEMS-1:0] taken_q, taken_d;
    prio_t              prio_q, prio_d;
    logic               idle_l, idle_r;
    logic [N_ITEMS-1:0] release_l, release_r;
    logic [N_ITEMS-1:0] award_mask_l, award_mask_r;
    lowest_t            cand_l, cand_r;
    logic               want_l, want_r, contested;

    assign clear = !reset_n || is_new_game_start;

    always_comb begin
        cand_l    = lowest_set(MaxItems'(hitl & ~taken_q & ~grantr));
        cand_r    = lowest_set(MaxItems'(hitr & ~taken_q & ~grantl));
        want_l    = idle_l && cand_l.valid;
        want_r    = idle_r && cand_r.valid;
        contested = want_l && want_r && (cand_l.idx == cand_r.idx);

        award_mask_l = '0;
        award_mask_r = '0;
        if (want_l && (!contested || prio_q == PrioLeft)) begin
            award_mask_l = N_ITEMS'(1) << cand_l.idx;
        end
        if (want_r && (!contested || prio_q == PrioRight)) begin
            award_mask_r = N_ITEMS'(1) << cand_r.idx;
        end

        prio_d  = contested ? ((prio_q == PrioLeft) ? PrioRight : PrioLeft) : prio_q;
        taken_d = (taken_q | award_mask_l | award_mask_r) & ~(release_l | release_r);
    end

    always_ff @(posedge Clk) begin
        if (clear) begin
            taken_q <= '0;
            prio_q  <= PrioLeft;
        end else begin
            taken_q <= taken_d;
            prio_q  <= prio_d;
        end
    end

    assign taken = taken_q;

    hook_claim_fsm #(
        .N_ITEMS        (N_ITEMS),
        .VAL_W          (VAL_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hook_l (
        .Clk          (Clk),
        .clear        (clear),
        .award_mask   (award_mask_l),
        .item_value   (item_value),
        .hook_home    (hook_homel),
        .is_explode   (is_explodel),
        .idle         (idle_l),
        .busy         (busyl),
        .grant        (grantl),
        .release_mask (release_l),
        .score_pulse  (score_pulsel),
        .score_add    (score_addl),
        .timeout      (timeoutl)
    );

    hook_claim_fsm #(
        .N_ITEMS        (N_ITEMS),
        .VAL_W          (VAL_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_hook_r (
        .Clk          (Clk),
        .clear        (clear),
        .award_mask   (award_mask_r),
        .item_value   (item_value),
        .hook_home    (hook_homer),
        .is_explode   (is_exploder),
        .idle         (idle_r),
        .busy         (busyr),
        .grant        (grantr),
        .release_mask (release_r),
        .score_pulse  (score_pulser),
        .score_add    (score_addr),
        .timeout      (timeoutr)
    );

endmodule

// File: tb/tb_gold_catch_arbiter.sv
// Bench for gold_catch_arbiter; strobes are checked against scoreboard queues.
module tb_gold_catch_arbiter;

    localparam int unsigned N  = 8;
    localparam int unsigned VW = 8;
    localparam int unsigned TO = 16;

    logic          Clk = 1'b0;
    logic          reset_n;
    logic          is_new_game_start;
    logic [N-1:0]  hitl, hitr;
    logic [N*VW-1:0] item_value;
    logic          hook_homel, hook_homer, is_explodel, is_exploder;
    logic [N-1:0]  grantl, grantr, taken;
    logic          busyl, busyr, score_pulsel, score_pulser, timeoutl, timeoutr;
    logic [VW-1:0] score_addl, score_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [VW-1:0] credit_l_q[$];
    logic [VW-1:0] credit_r_q[$];
    bit            timeout_l_q[$];

    always #5 Clk = ~Clk;

    gold_catch_arbiter #(
        .N_ITEMS        (N),
        .VAL_W          (VW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk               (Clk),
        .reset_n           (reset_n),
        .is_new_game_start (is_new_game_start),
        .hitl              (hitl),
        .hitr              (hitr),
        .item_value        (item_value),
        .hook_homel        (hook_homel),
        .hook_homer        (hook_homer),
        .is_explodel       (is_explodel),
        .is_exploder       (is_exploder),
        .grantl            (grantl),
        .grantr            (grantr),
        .taken             (taken),
        .busyl             (busyl),
        .busyr             (busyr),
        .score_pulsel      (score_pulsel),
        .score_pulser      (score_pulser),
        .score_addl        (score_addl),
        .score_addr        (score_addr),
        .timeoutl          (timeoutl),
        .timeoutr          (timeoutr)
    );

    function automatic logic [VW-1:0] val_of(input int i);
        return VW'(8'h11 * (i + 1));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then compare any strobes against the scoreboard.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (score_pulsel) begin
            if (credit_l_q.size() == 0) check_eq("pulsel_unexpected", 1, 0);
            else check_eq("score_addl", 32'(score_addl), 32'(credit_l_q.pop_front()));
        end else if (score_addl !== '0) begin
            check_eq("score_addl_idle", 32'(score_addl), 0);
        end
        if (score_pulser) begin
            if (credit_r_q.size() == 0) check_eq("pulser_unexpected", 1, 0);
            else check_eq("score_addr", 32'(score_addr), 32'(credit_r_q.pop_front()));
        end else if (score_addr !== '0) begin
            check_eq("score_addr_idle", 32'(score_addr), 0);
        end
        if (timeoutl) begin
            if (timeout_l_q.size() == 0) check_eq("timeoutl_unexpected", 1, 0);
            else check_eq("timeoutl", 1, 32'(timeout_l_q.pop_front()));
        end
        if (timeoutr !== 1'b0) check_eq("timeoutr_unexpected", 32'(timeoutr), 0);
    endtask

    task automatic new_game();
        is_new_game_start = 1'b1;
        tick();
        is_new_game_start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        is_new_game_start = 1'b0;
        hitl = '0; hitr = '0;
        hook_homel = 0; hook_homer = 0; is_explodel = 0; is_exploder = 0;
        for (int i = 0; i < N; i++) item_value[i*VW +: VW] = val_of(i);
        tick();
        tick();
        check_eq("rst_grantl", 32'(grantl), 0);
        check_eq("rst_grantr", 32'(grantr), 0);
        check_eq("rst_taken", 32'(taken), 0);
        check_eq("rst_busy", {30'b0, busyl, busyr}, 0);
        reset_n = 1'b1;

        // Single uncontested catch of item 2.
        hitl = 8'h04;
        tick();
        check_eq("a_grantl", 32'(grantl), 32'h04);
        check_eq("a_taken", 32'(taken), 32'h04);
        hitl = '0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("a_pull_grantl", 32'(grantl), 32'h04);
        hook_homel = 1'b1;
        credit_l_q.push_back(val_of(2));
        tick();
        hook_homel = 1'b0;
        check_eq("a_credit_seen", 32'(credit_l_q.size()), 0);
        tick();
        check_eq("a_done_grantl", 32'(grantl), 0);
        check_eq("a_done_taken", 32'(taken), 32'h04);
        check_eq("a_done_busyl", 32'(busyl), 0);

        // Contention: left wins first, right wins the next contest.
        new_game();
        check_eq("b_ng_taken", 32'(taken), 0);
        hitl = 8'h01; hitr = 8'h01;
        tick();
        check_eq("b1_grantl", 32'(grantl), 32'h01);
        check_eq("b1_grantr", 32'(grantr), 0);
        tick();
        check_eq("b1_masked_grantr", 32'(grantr), 0);
        check_eq("b1_masked_busyr", 32'(busyr), 0);
        hitl = '0; hitr = '0;
        hook_homel = 1'b1;
        credit_l_q.push_back(val_of(0));
        tick();
        hook_homel = 1'b0;
        tick();
        hitl = 8'h02; hitr = 8'h02;
        tick();
        check_eq("b2_grantr", 32'(grantr), 32'h02);
        check_eq("b2_grantl", 32'(grantl), 0);
        hitl = '0; hitr = '0;
        tick();
        hook_homer = 1'b1;
        credit_r_q.push_back(val_of(1));
        tick();
        hook_homer = 1'b0;
        tick();
        check_eq("b2_taken", 32'(taken), 32'h03);
        check_eq("b2_busyr", 32'(busyr), 0);
        new_game();
        hitl = 8'h02; hitr = 8'h02;
        tick();
        check_eq("b3_prio_reset_grantl", 32'(grantl), 32'h02);
        hitl = '0; hitr = '0;

        // Explode ignored in GRANT, wins over home in PULL.
        new_game();
        hitl = 8'h20;
        tick();
        hitl = '0;
        is_explodel = 1'b1; hook_homel = 1'b1;
        tick();
        check_eq("c_grant_ignores", 32'(grantl), 32'h20);
        tick();
        is_explodel = 1'b0; hook_homel = 1'b0;
        check_eq("c_blast_busyl", 32'(busyl), 1);
        tick();
        check_eq("c_busyl", 32'(busyl), 0);
        check_eq("c_grantl", 32'(grantl), 0);
        check_eq("c_taken", 32'(taken), 32'h20);

        // New game discards both in-flight pulls.
        new_game();
        hitl = 8'h01; hitr = 8'h80;
        tick();
        check_eq("d_grantl", 32'(grantl), 32'h01);
        check_eq("d_grantr", 32'(grantr), 32'h80);
        hitl = '0; hitr = '0;
        tick();
        new_game();
        hook_homel = 1'b1; hook_homer = 1'b1;
        tick();
        check_eq("d_grants", {16'(grantl), 16'(grantr)}, 0);
        check_eq("d_taken", 32'(taken), 0);
        check_eq("d_busy", {30'b0, busyl, busyr}, 0);
        tick();
        hook_homel = 1'b0; hook_homer = 1'b0;

`ifdef CATCH_TIMEOUT_EN
        // Pull abort after TO cycles; item becomes grantable again.
        new_game();
        hitl = 8'h08;
        tick();
        hitl = '0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        check_eq("e_still_pull", 32'(busyl), 1);
        timeout_l_q.push_back(1'b1);
        tick();
        check_eq("e_timeout_seen", 32'(timeout_l_q.size()), 0);
        check_eq("e_grantl", 32'(grantl), 0);
        check_eq("e_taken", 32'(taken), 0);
        hitl = 8'h08;
        tick();
        check_eq("e_regrant", 32'(grantl), 32'h08);
        hitl = '0;
`endif

        tick();
        check_eq("sb_credit_l_empty", 32'(credit_l_q.size()), 0);
        check_eq("sb_credit_r_empty", 32'(credit_r_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
